// File: rtl/y86_pkg.sv
// Shared definitions for the SEQ Y86-64 front end.
// Holds the icode constants, the 2-bit status codes, the "no register"
// specifier, the status FSM state type, and a helper that maps an icode to
// its instruction length and whether it carries a register byte.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;  // also cmovXX
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] STAT_AOK = 2'd0;
    localparam logic [1:0] STAT_HLT = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd2;
    localparam logic [1:0] STAT_INS = 2'd3;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_RUN       = 2'd0,
        ST_HALTED    = 2'd1,
        ST_FAULT_ADR = 2'd2,
        ST_FAULT_INS = 2'd3
    } state_e;

    typedef struct packed {
        logic [3:0] len;
        logic       need_reg;
    } ilen_t;

    // Invalid icodes report length 1 so the address check only looks at
    // the opcode byte itself.
    function automatic ilen_t instr_len(input logic [3:0] icode);
        ilen_t r;
        r.len      = 4'd1;
        r.need_reg = 1'b0;
        case (icode)
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                r.len      = 4'd2;
                r.need_reg = 1'b1;
            end
            I_JXX, I_CALL: begin
                r.len = 4'd9;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                r.len      = 4'd10;
                r.need_reg = 1'b1;
            end
            default: ;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fetch_split.sv
// Purely combinational instruction splitter.
// window : 10 bytes starting at pc, byte 0 in bits [7:0].
// icode/ifun : nibbles of byte 0.
// ra/rb      : register byte fields, REG_NONE when the instruction has none.
// valc       : little-endian constant, 0 when absent.
// len        : instruction length in bytes.
// valid      : icode/ifun combination is a legal instruction.
module fetch_split
    import y86_pkg::*;
(
    input  logic [79:0] window,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  ra,
    output logic [3:0]  rb,
    output logic [63:0] valc,
    output logic [3:0]  len,
    output logic        valid
);

    ilen_t il;

    assign icode = window[7:4];
    assign ifun  = window[3:0];
    assign il    = instr_len(icode);
    assign len   = il.len;

    always_comb begin
        ra   = REG_NONE;
        rb   = REG_NONE;
        valc = '0;
        if (il.need_reg) begin
            ra = window[15:12];
            rb = window[11:8];
        end
        // The constant follows the register byte when there is one.
        if (il.len == 4'd10) begin
            valc = window[79:16];
        end else if (il.len == 4'd9) begin
            valc = window[71:8];
        end
    end

    always_comb begin
        valid = 1'b0;
        case (icode)
            I_OPQ:             valid = (ifun <= 4'd3);
            I_RRMOVQ, I_JXX:   valid = (ifun <= 4'd6);
            I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ:
                               valid = (ifun == 4'h0);
            default:           valid = 1'b0;
        endcase
    end

endmodule

// File: rtl/seq_fetch.sv
// Fetch stage of the SEQ Y86-64 processor.
// Owns the PC register, a byte-addressed instruction memory, the processor
// status FSM and the retired-instruction counter. Fetch outputs are
// combinational from pc and memory.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   new_pc, pc_en         next PC and its load enable (0 = stall)
//   imem_we/waddr/wdata   program-load byte write port
//   pc                    current PC
//   icode..valP           split instruction fields
//   stat                  0=AOK 1=HLT 2=ADR 3=INS
//   instr_count           instructions accepted while running
//   dbg_state             status FSM state (state_e encoding)
module seq_fetch
    import y86_pkg::*;
#(
    parameter int          IMEM_BYTES = 1024,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] new_pc,
    input  logic        pc_en,
    input  logic        imem_we,
    input  logic [63:0] imem_waddr,
    input  logic [7:0]  imem_wdata,
    output logic [63:0] pc,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic [1:0]  stat,
    output logic [63:0] instr_count,
    output logic [1:0]  dbg_state
);

    localparam int          AW        = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [64:0] MEM_LIMIT = 65'(IMEM_BYTES);

    logic [7:0]  mem_q [IMEM_BYTES];
    logic [63:0] pc_q, pc_d;
    logic [63:0] count_q, count_d;
    state_e      state_q, state_d;

    logic [79:0] window;
    logic [3:0]  f_icode, f_ifun, f_ra, f_rb, f_len;
    logic [63:0] f_valc;
    logic        f_valid;
    logic [64:0] end_addr;
    logic        adr_err;
    logic [1:0]  fetch_stat;
    logic        in_run;
    logic        squash;

    // Program load port; writes land regardless of FSM state.
    always_ff @(posedge clk) begin
        if (imem_we && ({1'b0, imem_waddr} < MEM_LIMIT)) begin
            mem_q[imem_waddr[AW-1:0]] <= imem_wdata;
        end
    end

    // Bytes past the end of memory are never indexed; they read as 0.
    always_comb begin
        window = '0;
        for (int i = 0; i < 10; i++) begin
            if (({1'b0, pc_q} + 65'(i)) < MEM_LIMIT) begin
                window[8*i +: 8] = mem_q[AW'(pc_q + 64'(i))];
            end
        end
    end

    fetch_split u_split (
        .window (window),
        .icode  (f_icode),
        .ifun   (f_ifun),
        .ra     (f_ra),
        .rb     (f_rb),
        .valc   (f_valc),
        .len    (f_len),
        .valid  (f_valid)
    );

    // 65-bit so an instruction straddling 2^64 is still caught.
    assign end_addr = {1'b0, pc_q} + 65'(f_len) - 65'd1;
    assign adr_err  = ({1'b0, pc_q} >= MEM_LIMIT) || (end_addr >= MEM_LIMIT);

    always_comb begin
        if (adr_err) begin
            fetch_stat = STAT_ADR;
        end else if (!f_valid) begin
            fetch_stat = STAT_INS;
        end else if (f_icode == I_HALT) begin
            fetch_stat = STAT_HLT;
        end else begin
            fetch_stat = STAT_AOK;
        end
    end

    // Status FSM and PC/counter next-state.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        count_d = count_q;
        if (state_q == ST_RUN) begin
            case (fetch_stat)
                STAT_HLT: state_d = ST_HALTED;
                STAT_ADR: state_d = ST_FAULT_ADR;
                STAT_INS: state_d = ST_FAULT_INS;
                default: begin
                    if (pc_en) begin
                        pc_d    = new_pc;
                        count_d = count_q + 64'd1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_PC;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            count_q <= count_d;
        end
    end

    // A stopped machine, or a faulting fetch, presents a harmless bubble.
    assign in_run = (state_q == ST_RUN);
    assign squash = !in_run || (fetch_stat == STAT_ADR) || (fetch_stat == STAT_INS);

    always_comb begin
        icode = f_icode;
        ifun  = f_ifun;
        rA    = f_ra;
        rB    = f_rb;
        valC  = f_valc;
        valP  = pc_q + 64'(f_len);
        if (squash) begin
            icode = I_HALT;
            ifun  = 4'h0;
            rA    = REG_NONE;
            rB    = REG_NONE;
            valC  = '0;
            valP  = pc_q;
        end
    end

    always_comb begin
        case (state_q)
            ST_HALTED:    stat = STAT_HLT;
            ST_FAULT_ADR: stat = STAT_ADR;
            ST_FAULT_INS: stat = STAT_INS;
            default:      stat = fetch_stat;
        endcase
    end

    assign pc          = pc_q;
    assign instr_count = count_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_seq_fetch.sv
module tb_seq_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] new_pc;
    logic        pc_en;
    logic        imem_we;
    logic [63:0] imem_waddr;
    logic [7:0]  imem_wdata;
    logic [63:0] pc;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic [1:0]  stat;
    logic [63:0] instr_count;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    // clock / reset
    always #5 clk = ~clk;

    seq_fetch #(.IMEM_BYTES(1024), .RESET_PC(64'd0)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .new_pc      (new_pc),
        .pc_en       (pc_en),
        .imem_we     (imem_we),
        .imem_waddr  (imem_waddr),
        .imem_wdata  (imem_wdata),
        .pc          (pc),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .stat        (stat),
        .instr_count (instr_count),
        .dbg_state   (dbg_state)
    );

    typedef struct packed {
        logic [63:0] pc;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
        logic [1:0]  stat;
        logic [63:0] cnt;
        logic [1:0]  st;
    } exp_t;

    exp_t exp_q[$];

    typedef struct {
        logic [63:0] addr;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } vec_t;

    vec_t vecs[13];

    // scoreboard
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input logic [63:0] e_pc, input logic [3:0] e_icode,
                              input logic [3:0] e_ifun, input logic [3:0] e_ra,
                              input logic [3:0] e_rb, input logic [63:0] e_valc,
                              input logic [63:0] e_valp, input logic [1:0] e_stat,
                              input logic [63:0] e_cnt, input logic [1:0] e_st);
        exp_t e;
        e.pc = e_pc; e.icode = e_icode; e.ifun = e_ifun; e.ra = e_ra; e.rb = e_rb;
        e.valc = e_valc; e.valp = e_valp; e.stat = e_stat; e.cnt = e_cnt; e.st = e_st;
        exp_q.push_back(e);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: scoreboard empty, got pc %0h, expected an entry", tag, pc);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("%s.pc", tag),    pc,               e.pc);
            chk($sformatf("%s.icode", tag), 64'(icode),       64'(e.icode));
            chk($sformatf("%s.ifun", tag),  64'(ifun),        64'(e.ifun));
            chk($sformatf("%s.rA", tag),    64'(rA),          64'(e.ra));
            chk($sformatf("%s.rB", tag),    64'(rB),          64'(e.rb));
            chk($sformatf("%s.valC", tag),  valC,             e.valc);
            chk($sformatf("%s.valP", tag),  valP,             e.valp);
            chk($sformatf("%s.stat", tag),  64'(stat),        64'(e.stat));
            chk($sformatf("%s.count", tag), instr_count,      e.cnt);
            chk($sformatf("%s.state", tag), 64'(dbg_state),   64'(e.st));
        end
    endtask

    // driver tasks; every task starts and ends just after a falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [63:0] addr, input logic [7:0] d);
        imem_waddr = addr;
        imem_wdata = d;
        imem_we    = 1'b1;
        tick();
        imem_we    = 1'b0;
    endtask

    // v holds n bytes right-justified, first byte most significant.
    task automatic load(input logic [63:0] addr, input logic [79:0] v, input int n);
        for (int i = 0; i < n; i++) begin
            wr(addr + 64'(i), v[8*(n-1-i) +: 8]);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic step(input logic [63:0] npc, input logic en);
        new_pc = npc;
        pc_en  = en;
        tick();
    endtask

    initial begin
        rst_n      = 1'b0;
        new_pc     = '0;
        pc_en      = 1'b0;
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;

        vecs[0]  = '{64'd100,  4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'd102};
        vecs[1]  = '{64'd104,  4'h2, 4'h5, 4'h3, 4'h4, 64'd0, 64'd106};
        vecs[2]  = '{64'd120,  4'h4, 4'h0, 4'h1, 4'h5, 64'h0102030405060708, 64'd130};
        vecs[3]  = '{64'd130,  4'h5, 4'h0, 4'h6, 4'hF, 64'h123456789ABCDEF0, 64'd140};
        vecs[4]  = '{64'd140,  4'h6, 4'h3, 4'hA, 4'hB, 64'd0, 64'd142};
        vecs[5]  = '{64'd150,  4'h7, 4'h6, 4'hF, 4'hF, 64'h1122334455667788, 64'd159};
        vecs[6]  = '{64'd160,  4'h8, 4'h0, 4'hF, 4'hF, 64'h100, 64'd169};
        vecs[7]  = '{64'd170,  4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd171};
        vecs[8]  = '{64'd172,  4'hA, 4'h0, 4'h8, 4'hF, 64'd0, 64'd174};
        vecs[9]  = '{64'd180,  4'hB, 4'h0, 4'h9, 4'hF, 64'd0, 64'd182};
        vecs[10] = '{64'd1022, 4'h6, 4'h1, 4'h9, 4'h0, 64'd0, 64'd1024};
        vecs[11] = '{64'd1023, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1024};
        vecs[12] = '{64'd190,  4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'd191};

        @(negedge clk);
        // Clear and load the program while held in reset.
        for (int a = 0; a < 1024; a++) wr(64'(a), 8'h00);
        load(64'd0,    80'h30F20A00000000000000, 10);
        load(64'd10,   80'h00, 1);
        load(64'd100,  80'h2012, 2);
        load(64'd104,  80'h2534, 2);
        load(64'd120,  80'h40150807060504030201, 10);
        load(64'd130,  80'h506FF0DEBC9A78563412, 10);
        load(64'd140,  80'h63AB, 2);
        load(64'd150,  80'h768877665544332211, 9);
        load(64'd160,  80'h800001000000000000, 9);
        load(64'd170,  80'h90, 1);
        load(64'd172,  80'hA08F, 2);
        load(64'd180,  80'hB09F, 2);
        load(64'd190,  80'h10, 1);
        load(64'd200,  80'hC0, 1);
        load(64'd210,  80'h64, 1);
        load(64'd1020, 80'h30F06190, 4);
        // Out-of-range write must not alias onto byte 5.
        wr(64'd1029, 8'hFF);
        rst_n = 1'b1;

        // irmovq at 0, then halt at 10
        expect_out(64'd0, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 2'd0, 64'd0, 2'd0);
        check_out("reset");
        step(64'd10, 1'b1);
        expect_out(64'd10, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd11, 2'd1, 64'd1, 2'd0);
        check_out("hlt_comb");
        step(64'd11, 1'b1);
        expect_out(64'd10, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd10, 2'd1, 64'd1, 2'd1);
        check_out("halted");
        wr(64'd10, 8'h10);
        expect_out(64'd10, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd10, 2'd1, 64'd1, 2'd1);
        check_out("halt_sticky");

        // table of valid instructions, jumping between them
        do_reset();
        for (int k = 0; k < 13; k++) begin
            expect_out(vecs[k].addr, vecs[k].icode, vecs[k].ifun, vecs[k].ra, vecs[k].rb,
                       vecs[k].valc, vecs[k].valp, 2'd0, 64'(k + 1), 2'd0);
            step(vecs[k].addr, 1'b1);
            check_out($sformatf("vec%0d", k));
        end

        // write under the current pc while stalled: visible next cycle
        pc_en = 1'b0;
        wr(64'd190, 8'h90);
        expect_out(64'd190, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0, 64'd191, 2'd0, 64'd13, 2'd0);
        check_out("wr_then_rd");

        // invalid icode
        step(64'd200, 1'b1);
        expect_out(64'd200, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd200, 2'd3, 64'd14, 2'd0);
        check_out("ins_comb");
        step(64'd0, 1'b1);
        expect_out(64'd200, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd200, 2'd3, 64'd14, 2'd3);
        check_out("ins_latched");

        // invalid ifun, transition taken with pc_en low
        do_reset();
        step(64'd210, 1'b1);
        expect_out(64'd210, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd210, 2'd3, 64'd1, 2'd0);
        check_out("ins_ifun");
        step(64'd0, 1'b0);
        expect_out(64'd210, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd210, 2'd3, 64'd1, 2'd3);
        check_out("ins_nopcen");

        // instruction straddling the end of memory
        do_reset();
        step(64'd1020, 1'b1);
        expect_out(64'd1020, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1020, 2'd2, 64'd1, 2'd0);
        check_out("adr_comb");
        step(64'd0, 1'b1);
        expect_out(64'd1020, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'd1020, 2'd2, 64'd1, 2'd2);
        check_out("adr_latched");

        // pc at the top of the address space
        do_reset();
        step(64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
        expect_out(64'hFFFF_FFFF_FFFF_FFFF, 4'h0, 4'h0, 4'hF, 4'hF, 64'd0,
                   64'hFFFF_FFFF_FFFF_FFFF, 2'd2, 64'd1, 2'd0);
        check_out("adr_top");

        // stall, then asynchronous reset mid-cycle
        do_reset();
        step(64'd100, 1'b1);
        for (int s = 0; s < 3; s++) begin
            expect_out(64'd100, 4'h2, 4'h0, 4'h1, 4'h2, 64'd0, 64'd102, 2'd0, 64'd1, 2'd0);
            step(64'd0, 1'b0);
            check_out($sformatf("stall%0d", s));
        end
        #2 rst_n = 1'b0;
        #1;
        expect_out(64'd0, 4'h3, 4'h0, 4'hF, 4'h2, 64'd10, 64'd10, 2'd0, 64'd0, 2'd0);
        check_out("async_rst");
        @(negedge clk);
        rst_n = 1'b1;

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL leftover: %0d entries, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
